needs_engine: RTL and testbench
===============================

# needs_engine

Produces the six 4-bit need levels (hunger, happiness, health, hygiene, energy, social) that feed the status/state-detection stage. Levels decay over time on a prescaled game tick and are relieved by player actions delivered over a valid/ready handshake. A small FSM tracks awake, sleeping and dead conditions. Scale: 0 = fully satisfied, 12–14 = need, 15 = critical/dead; the downstream stage treats those thresholds accordingly.

## Interface
Parameters:
- TICK_DIV, 1000: clk cycles per game tick (≥2)
- ACTION_AMT, 4: amount an action subtracts from its need (1..15)
- SLEEP_TICKS, 8: maximum ticks spent asleep (1..255)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- action_valid  in  1  player action offered
- action_sel  in  3  action code: 0 feed, 1 play, 2 medicine, 3 clean, 4 sleep, 5 socialize, 6–7 no-op
- action_ready  out  1  block accepts an action this cycle
- hunger, happiness, health, hygiene, energy, social  out  4 each  need levels, registered
- asleep  out  1  FSM in SLEEP
- dead  out  1  FSM in DEAD

## Operation
- Reset: all levels 0, prescaler 0, phase 0, sleep counter 0, FSM AWAKE; action_ready=1, asleep=0, dead=0.
- Prescaler counts 0..TICK_DIV-1; tick is asserted for one cycle when count==TICK_DIV-1; count then wraps to 0.
- Phase counter 0..11 advances on each tick and wraps 11→0. On a tick, a need with decay period N increments when (phase mod N)==N-1, using the pre-increment phase. Periods: hunger 1, happiness 2, health 4, hygiene 3, energy 2, social 4.
- Handshake: action_ready = (state==AWAKE). An action is accepted on valid&&ready. action_sel is sampled only on acceptance; there is no queuing.
- Action effects:
  - Codes 0/2/3/5 subtract ACTION_AMT from hunger/health/hygiene/social.
  - Play subtracts ACTION_AMT from happiness and adds 1 to energy.
  - Sleep enters SLEEP.
  - Codes 6–7 are accepted with no effect.
- Per-need update, computed in 6-bit signed arithmetic: next = clamp(level + decay_inc + play_inc − action_dec, 0, 15). Decay and action in the same cycle combine in one step.
- FSM states:
  - AWAKE → SLEEP on an accepted sleep action.
  - SLEEP: energy does not decay and instead decrements by 1 per tick (floor 0). The sleep counter counts ticks. Other needs decay normally. SLEEP → AWAKE on the tick where energy next==0 or the sleep counter reaches SLEEP_TICKS. The sleep counter clears on entry.
  - Any state → DEAD when any next level ==15; DEAD takes precedence over the sleep exit.
  - DEAD: all levels, the phase and the sleep counter freeze; action_ready=0. Only rst leaves DEAD.

## Timing
- Levels, asleep and dead are all registered; dead rises on the same edge that a level first reads 15.
- With no actions, the first tick occurs at the TICK_DIV-th rising edge after rst deasserts. hunger=1 after that edge.
- An accepted action is visible on the levels one cycle after the accept edge. Sleep: asleep=1 and action_ready=0 from the next cycle.
- rst overrides everything, including mid-sleep and DEAD. Outputs return to reset values on the next edge.

## Structure
- needs_pkg:
  - action code localparams
  - FSM state enum {AWAKE, SLEEP, DEAD}
  - need index constants
  - decay period constants
  - 4-bit level typedef
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, rst, tick). Everything else is in needs_engine.

## Test plan
Use TICK_DIV=4, ACTION_AMT=4, SLEEP_TICKS=8 in simulation.
- Idle after reset → hunger=1 at cycle 4. Hunger reaches 15 at tick 15 (cycle 60): dead=1 and action_ready=0 that cycle; all levels frozen for 40 further cycles.
- hunger=6, feed accepted on a non-tick cycle → hunger=2. Feed again → hunger=0 (clamp); code 7 accepted → no level change.
- hunger=5 with feed accepted on a tick cycle (phase 0) → hunger=2 (5+1−4).
- Sleep entry and exit:
  - energy=3, sleep accepted → asleep=1 and action_ready=0 while action_valid is held high. After 3 ticks energy=0 → asleep=0, action_ready=1.
  - Repeat with energy=12 → wake after 8 ticks with energy=4.
- happiness=5, energy=14, play accepted → happiness=1, energy=15, dead=1 on the same edge.
- rst asserted for 1 cycle mid-sleep and again in DEAD → next cycle all levels 0, asleep=0, dead=0, action_ready=1; first tick 4 cycles later.

Source files
------------

// File: rtl/needs_pkg.sv
// Shared types and constants for the needs engine: action codes, FSM states,
// need indices, decay periods and the 4-bit level type.
package needs_pkg;

   localparam logic [2:0] ACT_FEED   = 3'd0;
   localparam logic [2:0] ACT_PLAY   = 3'd1;
   localparam logic [2:0] ACT_MED    = 3'd2;
   localparam logic [2:0] ACT_CLEAN  = 3'd3;
   localparam logic [2:0] ACT_SLEEP  = 3'd4;
   localparam logic [2:0] ACT_SOCIAL = 3'd5;

   typedef enum logic [1:0] {ST_AWAKE, ST_SLEEP, ST_DEAD} state_t;

   localparam int NUM_NEEDS = 6;
   localparam int N_HUNGER  = 0;
   localparam int N_HAPPY   = 1;
   localparam int N_HEALTH  = 2;
   localparam int N_HYGIENE = 3;
   localparam int N_ENERGY  = 4;
   localparam int N_SOCIAL  = 5;

   localparam int PER_HUNGER  = 1;
   localparam int PER_HAPPY   = 2;
   localparam int PER_HEALTH  = 4;
   localparam int PER_HYGIENE = 3;
   localparam int PER_ENERGY  = 2;
   localparam int PER_SOCIAL  = 4;

   typedef logic [3:0] level_t;
   localparam level_t LVL_MAX = 4'd15;

   function automatic int decay_period(input int idx);
      case (idx)
         N_HUNGER:  return PER_HUNGER;
         N_HAPPY:   return PER_HAPPY;
         N_HEALTH:  return PER_HEALTH;
         N_HYGIENE: return PER_HYGIENE;
         N_ENERGY:  return PER_ENERGY;
         default:   return PER_SOCIAL;
      endcase
   endfunction

   // True on the phase slot where a need with this period gains one level.
   function automatic logic decay_due(input int idx, input logic [3:0] phase);
      int p = decay_period(idx);
      return (int'(phase) % p) == (p - 1);
   endfunction

   function automatic logic relieves(input int idx, input logic [2:0] sel);
      case (idx)
         N_HUNGER:  return sel == ACT_FEED;
         N_HAPPY:   return sel == ACT_PLAY;
         N_HEALTH:  return sel == ACT_MED;
         N_HYGIENE: return sel == ACT_CLEAN;
         N_SOCIAL:  return sel == ACT_SOCIAL;
         default:   return 1'b0;
      endcase
   endfunction

   function automatic level_t clamp_level(input logic signed [5:0] v);
      if (v < 6'sd0) return 4'd0;
      else if (v > 6'sd15) return LVL_MAX;
      else return v[3:0];
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, on count TICK_DIV-1.
// Tick is combinational from the registered count; no backpressure.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/needs_engine.sv
// Six need levels decaying on a game tick, relieved by accepted actions; AWAKE/SLEEP/DEAD FSM.
// Levels update one cycle after accept; action_ready drops while asleep or dead (no queuing).
module needs_engine
   import needs_pkg::*;
#(
   parameter int TICK_DIV    = 1000,
   parameter int ACTION_AMT  = 4,
   parameter int SLEEP_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       action_valid,
   input  logic [2:0] action_sel,
   output logic       action_ready,
   output logic [3:0] hunger,
   output logic [3:0] happiness,
   output logic [3:0] health,
   output logic [3:0] hygiene,
   output logic [3:0] energy,
   output logic [3:0] social,
   output logic       asleep,
   output logic       dead
);

   localparam logic signed [5:0] AMT = 6'(ACTION_AMT);

   logic   tick;
   logic   accept;
   logic   any_crit;
   state_t state_q, state_d;
   logic [3:0] phase_q, phase_d;
   logic [7:0] slp_cnt_q, slp_cnt_d;
   level_t [NUM_NEEDS-1:0] lvl_q, lvl_d, lvl_nx;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Candidate next levels: decay, play bonus and relief folded into one signed step.
   always_comb begin
      logic signed [5:0] s;
      s        = '0;
      accept   = action_valid && (state_q == ST_AWAKE);
      any_crit = 1'b0;
      lvl_nx   = lvl_q;
      for (int i = 0; i < NUM_NEEDS; i++) begin
         s = $signed({2'b00, lvl_q[i]});
         if (i == N_ENERGY && state_q == ST_SLEEP) begin
            if (tick) s = s - 6'sd1;
         end else if (tick && decay_due(i, phase_q)) begin
            s = s + 6'sd1;
         end
         if (accept && relieves(i, action_sel)) s = s - AMT;
         if (accept && i == N_ENERGY && action_sel == ACT_PLAY) s = s + 6'sd1;
         lvl_nx[i] = clamp_level(s);
         if (lvl_nx[i] == LVL_MAX) any_crit = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      slp_cnt_d = slp_cnt_q;
      lvl_d     = lvl_q;
      case (state_q)
         ST_AWAKE: begin
            lvl_d = lvl_nx;
            if (tick) phase_d = (phase_q == 4'd11) ? 4'd0 : phase_q + 4'd1;
            if (any_crit) begin
               state_d = ST_DEAD;
            end else if (accept && action_sel == ACT_SLEEP) begin
               state_d   = ST_SLEEP;
               slp_cnt_d = '0;
            end
         end
         ST_SLEEP: begin
            lvl_d = lvl_nx;
            if (tick) begin
               phase_d   = (phase_q == 4'd11) ? 4'd0 : phase_q + 4'd1;
               slp_cnt_d = slp_cnt_q + 8'd1;
            end
            // Death wins over waking on the same tick.
            if (any_crit) begin
               state_d = ST_DEAD;
            end else if (tick && (lvl_nx[N_ENERGY] == 4'd0 ||
                                  slp_cnt_d == 8'(SLEEP_TICKS))) begin
               state_d = ST_AWAKE;
            end
         end
         default: begin
            state_d = ST_DEAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_AWAKE;
         phase_q   <= '0;
         slp_cnt_q <= '0;
         lvl_q     <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         slp_cnt_q <= slp_cnt_d;
         lvl_q     <= lvl_d;
      end
   end

   assign action_ready = (state_q == ST_AWAKE);
   assign asleep       = (state_q == ST_SLEEP);
   assign dead         = (state_q == ST_DEAD);
   assign hunger       = lvl_q[N_HUNGER];
   assign happiness    = lvl_q[N_HAPPY];
   assign health       = lvl_q[N_HEALTH];
   assign hygiene      = lvl_q[N_HYGIENE];
   assign energy       = lvl_q[N_ENERGY];
   assign social       = lvl_q[N_SOCIAL];

endmodule

// File: tb/tb_needs_engine.sv
// Directed bench for needs_engine with TICK_DIV=4; edge counts are relative to the reset edge.
module tb_needs_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       action_valid = 1'b0;
   logic [2:0] action_sel = 3'd0;
   logic       action_ready;
   logic [3:0] hunger, happiness, health, hygiene, energy, social;
   logic       asleep, dead;

   int n_cmp = 0;
   int n_bad = 0;

   needs_engine #(.TICK_DIV(4), .ACTION_AMT(4), .SLEEP_TICKS(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .action_valid (action_valid),
      .action_sel   (action_sel),
      .action_ready (action_ready),
      .hunger       (hunger),
      .happiness    (happiness),
      .health       (health),
      .hygiene      (hygiene),
      .energy       (energy),
      .social       (social),
      .asleep       (asleep),
      .dead         (dead)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_lv(input string tag, input int h, input int hp, input int he,
                         input int hy, input int en, input int so);
      chk({tag, ".hunger"},    hunger,    h);
      chk({tag, ".happiness"}, happiness, hp);
      chk({tag, ".health"},    health,    he);
      chk({tag, ".hygiene"},   hygiene,   hy);
      chk({tag, ".energy"},    energy,    en);
      chk({tag, ".social"},    social,    so);
   endtask

   task automatic chk_fsm(input string tag, input int rdy, input int slp, input int dd);
      chk({tag, ".ready"},  action_ready, rdy);
      chk({tag, ".asleep"}, asleep,       slp);
      chk({tag, ".dead"},   dead,         dd);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      action_valid = 1'b0;
      step(1);
      rst = 1'b0;
   endtask

   task automatic act(input logic [2:0] sel);
      action_valid = 1'b1;
      action_sel   = sel;
      step(1);
      action_valid = 1'b0;
   endtask

   initial begin
      step(2);

      // Idle decay to death, then freeze.
      do_reset();
      chk_lv("rst", 0, 0, 0, 0, 0, 0);
      chk_fsm("rst", 1, 0, 0);
      step(3);
      chk("idle.e3.hunger", hunger, 0);
      step(1);
      chk_lv("idle.e4", 1, 0, 0, 0, 0, 0);
      step(55);
      chk("idle.e59.hunger", hunger, 14);
      chk("idle.e59.dead", dead, 0);
      step(1);
      chk_lv("idle.e60", 15, 7, 3, 5, 7, 3);
      chk_fsm("idle.e60", 0, 0, 1);
      step(40);
      chk_lv("idle.frozen", 15, 7, 3, 5, 7, 3);
      chk("idle.frozen.dead", dead, 1);

      // Feed on non-tick cycles, clamp, no-op code.
      do_reset();
      step(24);
      chk_lv("feed.e24", 6, 3, 1, 2, 3, 1);
      act(3'd0);
      chk("feed.e25.hunger", hunger, 2);
      act(3'd0);
      chk("feed.clamp.hunger", hunger, 0);
      act(3'd7);
      chk_lv("feed.noop", 0, 3, 1, 2, 3, 1);
      chk("feed.noop.ready", action_ready, 1);

      // Feed on a phase-0 tick: decay and relief in one step.
      do_reset();
      step(28);
      chk("tickfeed.e28.hunger", hunger, 7);
      act(3'd0);
      act(3'd0);
      chk("tickfeed.e30.hunger", hunger, 0);
      step(18);
      chk_lv("tickfeed.e48", 5, 6, 3, 4, 6, 3);
      step(3);
      act(3'd0);
      chk_lv("tickfeed.e52", 2, 6, 3, 4, 6, 3);

      // Sleep from energy 3 with valid held: wake when energy hits 0.
      do_reset();
      step(24);
      chk("sleep3.e24.energy", energy, 3);
      action_valid = 1'b1;
      action_sel   = 3'd4;
      step(1);
      chk_fsm("sleep3.e25", 0, 1, 0);
      chk("sleep3.e25.energy", energy, 3);
      step(3);
      chk("sleep3.e28.energy", energy, 2);
      step(4);
      chk("sleep3.e32.energy", energy, 1);
      step(3);
      chk_fsm("sleep3.e35", 0, 1, 0);
      step(1);
      chk_fsm("sleep3.e36", 1, 0, 0);
      chk("sleep3.e36.energy", energy, 0);
      chk("sleep3.e36.hunger", hunger, 9);
      chk("sleep3.e36.happiness", happiness, 4);
      action_valid = 1'b0;

      // Sleep from energy 12: sleep counter limit wakes after 8 ticks.
      do_reset();
      action_valid = 1'b1;
      action_sel   = 3'd1;
      step(11);
      action_valid = 1'b0;
      chk("sleep12.e11.energy", energy, 12);
      chk("sleep12.e11.happiness", happiness, 0);
      chk("sleep12.e11.hunger", hunger, 2);
      act(3'd4);
      chk("sleep12.e12.asleep", asleep, 1);
      chk("sleep12.e12.energy", energy, 12);
      step(28);
      chk("sleep12.e40.energy", energy, 5);
      chk("sleep12.e40.asleep", asleep, 1);
      step(4);
      chk("sleep12.e44.energy", energy, 4);
      chk_fsm("sleep12.e44", 1, 0, 0);
      chk("sleep12.e44.hunger", hunger, 11);

      // Play pushes energy to 15: dead on the same edge.
      do_reset();
      action_valid = 1'b1;
      action_sel   = 3'd1;
      step(8);
      action_valid = 1'b0;
      chk("play.e8.energy", energy, 9);
      step(40);
      chk_lv("play.e48", 12, 5, 3, 4, 14, 3);
      chk("play.e48.dead", dead, 0);
      act(3'd1);
      chk_lv("play.e49", 12, 1, 3, 4, 15, 3);
      chk_fsm("play.e49", 0, 0, 1);
      step(5);
      chk_lv("play.frozen", 12, 1, 3, 4, 15, 3);

      // Reset out of DEAD.
      do_reset();
      chk_lv("rstdead", 0, 0, 0, 0, 0, 0);
      chk_fsm("rstdead", 1, 0, 0);
      step(3);
      chk("rstdead.e3.hunger", hunger, 0);
      step(1);
      chk("rstdead.e4.hunger", hunger, 1);

      // Reset in the middle of sleep.
      do_reset();
      act(3'd4);
      chk("rstslp.e1.asleep", asleep, 1);
      step(1);
      chk("rstslp.e2.asleep", asleep, 1);
      do_reset();
      chk_lv("rstslp", 0, 0, 0, 0, 0, 0);
      chk_fsm("rstslp", 1, 0, 0);
      step(3);
      chk("rstslp.e3.hunger", hunger, 0);
      step(1);
      chk("rstslp.e4.hunger", hunger, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
